// File: rtl/calc_queue_pkg.sv
// Shared definitions for the queue calculator: queue command encodings (also used by
// the ALU stage), error codes reported by calc_queue, and the calc_queue FSM states.
package calc_queue_pkg;

  // Queue commands issued by the ALU
  localparam logic [1:0] Q_PUSH         = 2'b00;
  localparam logic [1:0] Q_SLEEP        = 2'b01;
  localparam logic [1:0] Q_GET_AND_PUSH = 2'b10;
  localparam logic [1:0] Q_POP          = 2'b11;

  // Sticky error codes
  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_OVF  = 2'b01;
  localparam logic [1:0] ERR_UNF  = 2'b10;
  localparam logic [1:0] ERR_CALC = 2'b11;

  typedef enum logic {
    StReady = 1'b0,
    StError = 1'b1
  } state_e;

endpackage

// File: rtl/calc_queue_regfile.sv
// queue_regfile: Depth x Width storage for calc_queue. One synchronous write port and two
// combinational read ports (head and head+1). Contents are not reset.
// Ports:
//   clk_i            clock
//   we_i/waddr_i/wdata_i   write port, written on the rising edge when we_i is high
//   raddr0_i/rdata0_o      read port 0 (head)
//   raddr1_i/rdata1_o      read port 1 (head+1)
module queue_regfile #(
  parameter int unsigned Depth = 16,
  parameter int unsigned Width = 8
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(Depth)-1:0] waddr_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic [$clog2(Depth)-1:0] raddr0_i,
  input  logic [$clog2(Depth)-1:0] raddr1_i,
  output logic [Width-1:0]         rdata0_o,
  output logic [Width-1:0]         rdata1_o
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata0_o = mem_q[raddr0_i];
  assign rdata1_o = mem_q[raddr1_i];

endmodule

// File: rtl/calc_queue.sv
// calc_queue: operand queue downstream of the ALU. Executes the ALU's queue command with
// its result and feeds the two head entries back as operands. Holds the circular
// pointers, occupancy count, READY/ERROR FSM and sticky error code.
// Ports:
//   clk_i, rst_i        clock; synchronous active-high reset
//   cmd_valid_i         command presented this cycle
//   queue_op_i          Q_PUSH / Q_SLEEP / Q_POP / Q_GET_AND_PUSH
//   result_i            data pushed by PUSH and GET_AND_PUSH
//   calc_err_i          ALU calculation error, sampled with the command
//   clr_err_i           leaves ERROR and clears err_code
//   cmd_ready_o         high in READY
//   operands_o          {entry[head+1], entry[head]}, invalid slots read 0
//   head_val_o          entry[head], 0 when empty
//   empty_o, full_o     occupancy flags
//   err_o, err_code_o   ERROR state and sticky error code
// Optional (macro CALC_QUEUE_LEVEL_EN):
//   level_o             current occupancy
//   level_max_o         high-water mark of occupancy, cleared only by reset
// DEPTH must be a power of 2 and at least 2.
module calc_queue
  import calc_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cmd_valid_i,
  input  logic [1:0]             queue_op_i,
  input  logic [WIDTH-1:0]       result_i,
  input  logic                   calc_err_i,
  input  logic                   clr_err_i,
  output logic                   cmd_ready_o,
  output logic [2*WIDTH-1:0]     operands_o,
  output logic [WIDTH-1:0]       head_val_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic                   err_o,
`ifdef CALC_QUEUE_LEVEL_EN
  output logic [$clog2(DEPTH):0] level_o,
  output logic [$clog2(DEPTH):0] level_max_o,
`endif
  output logic [1:0]             err_code_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  state_e            state_q, state_d;
  logic [PtrW-1:0]   head_q, head_d;
  logic [PtrW-1:0]   tail_q, tail_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [1:0]        err_code_q, err_code_d;
  logic              we;
  logic [WIDTH-1:0]  rdata0, rdata1;
  logic              accept;
  logic              is_empty, is_full;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CntW'(DEPTH));
  assign accept   = cmd_valid_i && (state_q == StReady);

  queue_regfile #(
    .Depth (DEPTH),
    .Width (WIDTH)
  ) u_regfile (
    .clk_i    (clk_i),
    .we_i     (we),
    .waddr_i  (tail_q),
    .wdata_i  (result_i),
    .raddr0_i (head_q),
    .raddr1_i (head_q + PtrW'(1)),
    .rdata0_o (rdata0),
    .rdata1_o (rdata1)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StReady;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      err_code_q <= err_code_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    err_code_d = err_code_q;
    we         = 1'b0;

    if (accept) begin
      if (calc_err_i) begin
        state_d    = StError;
        err_code_d = ERR_CALC;
      end else begin
        unique case (queue_op_i)
          Q_PUSH: begin
            if (is_full) begin
              state_d    = StError;
              err_code_d = ERR_OVF;
            end else begin
              we      = 1'b1;
              tail_d  = tail_q + PtrW'(1);
              count_d = count_q + CntW'(1);
            end
          end
          Q_POP: begin
            if (is_empty) begin
              state_d    = StError;
              err_code_d = ERR_UNF;
            end else begin
              head_d  = head_q + PtrW'(1);
              count_d = count_q - CntW'(1);
            end
          end
          Q_GET_AND_PUSH: begin
            if (count_q < CntW'(2)) begin
              state_d    = StError;
              err_code_d = ERR_UNF;
            end else begin
              // When full the write slot is the old head; the operands were already
              // consumed this cycle, so overwriting it is safe.
              we      = 1'b1;
              head_d  = head_q + PtrW'(2);
              tail_d  = tail_q + PtrW'(1);
              count_d = count_q - CntW'(1);
            end
          end
          default: ;  // Q_SLEEP
        endcase
      end
    end else if ((state_q == StError) && clr_err_i) begin
      state_d    = StReady;
      err_code_d = ERR_NONE;
    end
  end

  assign cmd_ready_o = (state_q == StReady);
  assign err_o       = (state_q == StError);
  assign err_code_o  = err_code_q;
  assign empty_o     = is_empty;
  assign full_o      = is_full;
  assign head_val_o  = is_empty ? '0 : rdata0;
  assign operands_o  = {(count_q >= CntW'(2)) ? rdata1 : {WIDTH{1'b0}}, head_val_o};

`ifdef CALC_QUEUE_LEVEL_EN
  logic [CntW-1:0] level_max_q, level_max_d;

  always_comb begin
    level_max_d = level_max_q;
    if (count_d > level_max_q) begin
      level_max_d = count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      level_max_q <= '0;
    end else begin
      level_max_q <= level_max_d;
    end
  end

  assign level_o     = count_q;
  assign level_max_o = level_max_q;
`endif

endmodule

// File: tb/tb_calc_queue.sv
// Self-checking bench for calc_queue: directed scenarios plus randomized commands, all
// checked against a queue-based behavioural model.
module tb_calc_queue;

  localparam int DEPTH = 16;
  localparam int WIDTH = 8;

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_SLEEP = 2'b01;
  localparam logic [1:0] OP_GAP = 2'b10;
  localparam logic [1:0] OP_POP = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  queue_op = 2'b01;
  logic [7:0]  result = 8'h00;
  logic        calc_err = 1'b0;
  logic        clr_err = 1'b0;
  logic        cmd_ready;
  logic [15:0] operands;
  logic [7:0]  head_val;
  logic        empty;
  logic        full;
  logic        err;
  logic [1:0]  err_code;
`ifdef CALC_QUEUE_LEVEL_EN
  logic [4:0]  level;
  logic [4:0]  level_max;
`endif

  int checks = 0;
  int errors = 0;

  // Behavioural model
  logic [7:0] mq[$];
  logic       m_err = 1'b0;
  logic [1:0] m_code = 2'b00;
  int         m_max = 0;

  calc_queue #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cmd_valid_i (cmd_valid),
    .queue_op_i  (queue_op),
    .result_i    (result),
    .calc_err_i  (calc_err),
    .clr_err_i   (clr_err),
    .cmd_ready_o (cmd_ready),
    .operands_o  (operands),
    .head_val_o  (head_val),
    .empty_o     (empty),
    .full_o      (full),
    .err_o       (err),
`ifdef CALC_QUEUE_LEVEL_EN
    .level_o     (level),
    .level_max_o (level_max),
`endif
    .err_code_o  (err_code)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] exp_ops();
    if (mq.size() == 0) return 16'h0000;
    if (mq.size() == 1) return {8'h00, mq[0]};
    return {mq[1], mq[0]};
  endfunction

  function automatic logic [7:0] exp_head();
    if (mq.size() == 0) return 8'h00;
    return mq[0];
  endfunction

  task automatic model_step(input logic v, input logic [1:0] op, input logic [7:0] res,
                            input logic ce, input logic clr, input logic r);
    if (r) begin
      mq.delete();
      m_err  = 1'b0;
      m_code = 2'b00;
      m_max  = 0;
    end else if (v && !m_err) begin
      if (ce) begin
        m_err = 1'b1; m_code = 2'b11;
      end else if (op == OP_PUSH) begin
        if (mq.size() == DEPTH) begin
          m_err = 1'b1; m_code = 2'b01;
        end else mq.push_back(res);
      end else if (op == OP_POP) begin
        if (mq.size() == 0) begin
          m_err = 1'b1; m_code = 2'b10;
        end else void'(mq.pop_front());
      end else if (op == OP_GAP) begin
        if (mq.size() < 2) begin
          m_err = 1'b1; m_code = 2'b10;
        end else begin
          void'(mq.pop_front());
          void'(mq.pop_front());
          mq.push_back(res);
        end
      end
    end else if (m_err && clr) begin
      m_err = 1'b0; m_code = 2'b00;
    end
    if (mq.size() > m_max) m_max = mq.size();
  endtask

  // Drive one cycle of inputs, update the model at the edge, leave time at edge+1.
  task automatic cycle(input logic v, input logic [1:0] op, input logic [7:0] res,
                       input logic ce, input logic clr, input logic r);
    cmd_valid = v; queue_op = op; result = res; calc_err = ce; clr_err = clr; rst = r;
    @(posedge clk);
    model_step(v, op, res, ce, clr, r);
    #1;
    cmd_valid = 1'b0; calc_err = 1'b0; clr_err = 1'b0; rst = 1'b0;
  endtask

  task automatic do_reset();
    cycle(1'b0, OP_SLEEP, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic fill_1_to_16();
    for (int i = 1; i <= DEPTH; i++) cycle(1'b1, OP_PUSH, 8'(i), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_flags got empty=%b full=%b exp 1/0", empty, full); end
    checks++; if (err !== 1'b0 || err_code !== 2'b00) begin errors++; $display("FAIL reset_err got err=%b code=%b exp 0/00", err, err_code); end
    checks++; if (operands !== 16'h0 || head_val !== 8'h0) begin errors++; $display("FAIL reset_data got ops=%h head=%h exp 0/0", operands, head_val); end
  endtask

  task automatic test_push_pair();
    cycle(1'b1, OP_PUSH, 8'h05, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, OP_PUSH, 8'h03, 1'b0, 1'b0, 1'b0);
    checks++; if (operands !== 16'h0305) begin errors++; $display("FAIL push_pair_ops got=%h exp=0305", operands); end
    checks++; if (head_val !== 8'h05 || empty !== 1'b0) begin errors++; $display("FAIL push_pair_head got=%h empty=%b exp 05/0", head_val, empty); end
`ifdef CALC_QUEUE_LEVEL_EN
    checks++; if (level !== 5'd2) begin errors++; $display("FAIL push_pair_level got=%0d exp=2", level); end
`endif
  endtask

  task automatic test_get_and_push();
    cycle(1'b1, OP_GAP, 8'h08, 1'b0, 1'b0, 1'b0);
    checks++; if (head_val !== 8'h08) begin errors++; $display("FAIL gap_head got=%h exp=08", head_val); end
    checks++; if (operands !== 16'h0008) begin errors++; $display("FAIL gap_ops got=%h exp=0008", operands); end
  endtask

  task automatic test_overflow();
    do_reset();
    fill_1_to_16();
    checks++; if (full !== 1'b1 || operands !== 16'h0201) begin errors++; $display("FAIL fill got full=%b ops=%h exp 1/0201", full, operands); end
    cycle(1'b1, OP_PUSH, 8'h11, 1'b0, 1'b0, 1'b0);
    checks++; if (err !== 1'b1 || err_code !== 2'b01 || cmd_ready !== 1'b0) begin errors++; $display("FAIL ovf got err=%b code=%b rdy=%b exp 1/01/0", err, err_code, cmd_ready); end
    checks++; if (full !== 1'b1 || head_val !== 8'h01) begin errors++; $display("FAIL ovf_keep got full=%b head=%h exp 1/01", full, head_val); end
    // Commands while in ERROR are ignored
    cycle(1'b1, OP_POP, 8'h00, 1'b0, 1'b0, 1'b0);
    checks++; if (head_val !== 8'h01 || err_code !== 2'b01) begin errors++; $display("FAIL err_ignore got head=%h code=%b exp 01/01", head_val, err_code); end
    cycle(1'b0, OP_SLEEP, 8'h00, 1'b0, 1'b1, 1'b0);
    checks++; if (cmd_ready !== 1'b1 || err !== 1'b0 || err_code !== 2'b00) begin errors++; $display("FAIL ovf_clr got rdy=%b err=%b code=%b exp 1/0/00", cmd_ready, err, err_code); end
    checks++; if (head_val !== 8'h01 || full !== 1'b1) begin errors++; $display("FAIL ovf_clr_keep got head=%h full=%b exp 01/1", head_val, full); end
  endtask

  task automatic test_underflow();
    do_reset();
    cycle(1'b1, OP_POP, 8'h00, 1'b0, 1'b0, 1'b0);
    checks++; if (err_code !== 2'b10 || cmd_ready !== 1'b0) begin errors++; $display("FAIL unf_pop got code=%b rdy=%b exp 10/0", err_code, cmd_ready); end
    cycle(1'b0, OP_SLEEP, 8'h00, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, OP_PUSH, 8'h07, 1'b0, 1'b0, 1'b0);
    checks++; if (operands !== 16'h0007 || empty !== 1'b0) begin errors++; $display("FAIL unf_push got ops=%h empty=%b exp 0007/0", operands, empty); end
    // GET_AND_PUSH with one entry underflows and leaves the queue alone
    cycle(1'b1, OP_GAP, 8'h55, 1'b0, 1'b0, 1'b0);
    checks++; if (err_code !== 2'b10 || operands !== 16'h0007) begin errors++; $display("FAIL unf_gap got code=%b ops=%h exp 10/0007", err_code, operands); end
    // clr_err in READY does nothing
    cycle(1'b0, OP_SLEEP, 8'h00, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, OP_SLEEP, 8'h00, 1'b0, 1'b1, 1'b0);
    checks++; if (err !== 1'b0 || cmd_ready !== 1'b1 || operands !== 16'h0007) begin errors++; $display("FAIL clr_ready got err=%b rdy=%b ops=%h exp 0/1/0007", err, cmd_ready, operands); end
  endtask

  task automatic test_full_gap_wrap();
    do_reset();
    fill_1_to_16();
    cycle(1'b1, OP_GAP, 8'hAA, 1'b0, 1'b0, 1'b0);
    checks++; if (full !== 1'b0 || operands !== 16'h0403) begin errors++; $display("FAIL full_gap got full=%b ops=%h exp 0/0403", full, operands); end
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, (i % 2 == 0) ? OP_PUSH : OP_POP, 8'($urandom), 1'b0, 1'b0, 1'b0);
      checks++; if (operands !== exp_ops() || err !== 1'b0) begin errors++; $display("FAIL wrap_%0d got ops=%h err=%b exp %h/0", i, operands, err, exp_ops()); end
    end
    while (mq.size() > 0) begin
      cycle(1'b1, OP_POP, 8'h00, 1'b0, 1'b0, 1'b0);
      checks++; if (head_val !== exp_head()) begin errors++; $display("FAIL drain got=%h exp=%h", head_val, exp_head()); end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got=%b exp=1", empty); end
  endtask

  task automatic test_calc_err();
    do_reset();
    cycle(1'b1, OP_PUSH, 8'h21, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, OP_PUSH, 8'h42, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, OP_POP, 8'h00, 1'b1, 1'b0, 1'b0);
    checks++; if (err_code !== 2'b11 || err !== 1'b1 || operands !== 16'h4221) begin errors++; $display("FAIL calc_err got code=%b err=%b ops=%h exp 11/1/4221", err_code, err, operands); end
    cycle(1'b1, OP_PUSH, 8'h99, 1'b0, 1'b1, 1'b1);
    checks++; if (err !== 1'b0 || err_code !== 2'b00 || cmd_ready !== 1'b1 || empty !== 1'b1 || operands !== 16'h0) begin errors++; $display("FAIL rst_in_err got err=%b code=%b rdy=%b empty=%b ops=%h exp 0/00/1/1/0", err, err_code, cmd_ready, empty, operands); end
    // Reset wins over an accepted command in the same cycle
    cycle(1'b1, OP_PUSH, 8'h13, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, OP_PUSH, 8'h77, 1'b0, 1'b0, 1'b1);
    checks++; if (empty !== 1'b1 || head_val !== 8'h00) begin errors++; $display("FAIL rst_vs_cmd got empty=%b head=%h exp 1/00", empty, head_val); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic [1:0] op;
      logic       ce;
      logic       clr;
      int         r;
      r   = $urandom_range(0, 9);
      // Bias towards pushes so the queue visits both full and empty
      op  = (r < 4) ? OP_PUSH : (r < 6) ? OP_POP : (r < 8) ? OP_GAP : OP_SLEEP;
      ce  = ($urandom_range(0, 31) == 0);
      clr = ($urandom_range(0, 2) == 0);
      cycle($urandom_range(0, 4) != 0, op, 8'($urandom), ce, clr, 1'b0);
      checks++;
      if (operands !== exp_ops() || head_val !== exp_head() || err !== m_err ||
          err_code !== m_code || cmd_ready !== !m_err || empty !== (mq.size() == 0) ||
          full !== (mq.size() == DEPTH)) begin
        errors++;
        $display("FAIL rand_%0d got ops=%h head=%h err=%b code=%b rdy=%b empty=%b full=%b exp ops=%h head=%h err=%b code=%b size=%0d",
                 i, operands, head_val, err, err_code, cmd_ready, empty, full,
                 exp_ops(), exp_head(), m_err, m_code, mq.size());
      end
`ifdef CALC_QUEUE_LEVEL_EN
      checks++;
      if (level !== 5'(mq.size()) || level_max !== 5'(m_max)) begin
        errors++;
        $display("FAIL rand_level_%0d got level=%0d max=%0d exp %0d/%0d", i, level, level_max, mq.size(), m_max);
      end
`endif
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_push_pair();
    test_get_and_push();
    test_overflow();
    test_underflow();
    test_full_gap_wrap();
    test_calc_err();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc_queue.md
# calc_queue

Operand queue for the queue calculator; sits directly downstream of the ALU stage. Executes the ALU's 2-bit queue command (`queue_op`) with its 8-bit `result`, and feeds the two head entries back to the ALU as `operands`. Owns storage, the circular pointers, the occupancy count, and sticky overflow, underflow and calculation-error reporting.

## Interface
- DEPTH, 16: number of 8-bit entries; must be a power of 2 and at least 2.
- WIDTH, 8: entry width; `operands` is 2*WIDTH wide.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset rst, synchronous, active-high.
- cmd_valid  in  1  a command is presented this cycle.
- queue_op  in  2  command: 00 PUSH, 01 SLEEP, 11 POP, 10 GET_AND_PUSH.
- result  in  WIDTH  value to push for PUSH and GET_AND_PUSH.
- calc_err  in  1  ALU calculation error, sampled with the command.
- clr_err  in  1  single-cycle pulse; leaves ERROR.
- cmd_ready  out  1  high in READY state only.
- operands  out  2*WIDTH  {entry[head+1], entry[head]}; invalid slots read 0.
- head_val  out  WIDTH  entry[head]; 0 when empty.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- err  out  1  high in ERROR state.
- err_code  out  2  00 none, 01 overflow, 10 underflow, 11 calc error.

## Operation
- States: READY and ERROR.
  - READY to ERROR on any faulting accepted command.
  - ERROR to READY on clr_err; this also clears err_code.
- A command is accepted when cmd_valid && cmd_ready. With cmd_valid low, or in ERROR, nothing changes.
- Accepted command, checked in priority order:
  - calc_err=1: queue unchanged; go to ERROR with err_code 11.
  - PUSH: if full, go to ERROR with code 01 and leave the queue unchanged. Otherwise write result at tail; tail+1, count+1.
  - POP: if empty, go to ERROR with code 10. Otherwise head+1, count-1.
  - GET_AND_PUSH: if count<2, go to ERROR with code 10 and leave the queue unchanged. Otherwise head+2, write result at the old tail, tail+1, count-1.
  - GET_AND_PUSH when full: the write slot equals the old head. This is legal, because the operands were read before the edge.
  - SLEEP: no change.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
- operands and head_val are combinational from the registered state. Upper byte of operands is 0 when count<2; whole bus is 0 when empty.
- Queue contents are preserved across ERROR and clr_err.

## Timing
- Reset: head=0, tail=0, count=0, state READY.
- Outputs after reset: cmd_ready=1, empty=1, full=0, err=0, err_code=00, operands=0, head_val=0.
- Latency: an accepted command updates pointers, count, flags and operands on the next rising edge, one cycle.
- Back-to-back commands run at one per cycle.
- The ALU path from operands through result into the write data is combinational within a single cycle.
- cmd_ready falls in the cycle after a faulting command is accepted.
- clr_err in ERROR gives cmd_ready=1 on the next cycle. clr_err in READY has no effect.
- rst has priority over every other input, including in ERROR and in the same cycle as an accepted command.

## Configuration
- CALC_QUEUE_LEVEL_EN defined:
  - adds output port `level` (log2(DEPTH)+1 bits) equal to count.
  - adds a registered high-water mark `level_max`, cleared only by rst.
- Undefined: neither port exists. Queue behaviour is identical.

## Structure
- Shared package `calc_queue_pkg` holds:
  - queue command constants Q_PUSH, Q_SLEEP, Q_POP, Q_GET_AND_PUSH, shared with the ALU.
  - err_code constants ERR_NONE, ERR_OVF, ERR_UNF, ERR_CALC.
  - the state enum.
- Sub-module `queue_regfile`: DEPTH x WIDTH register array with one synchronous write port and two combinational read ports (head, head+1). No reset of contents.
- calc_queue top contains the pointers, count, FSM and error logic.

## Test plan
- Reset, then PUSH 5 and PUSH 3 → operands=0x0305, count 2, head_val=5.
- From the previous state, GET_AND_PUSH with result=8 → count 1, head_val=8, operands=0x0008.
- DEPTH PUSHes of 1..16, then a 17th PUSH → err=1, err_code=01, cmd_ready=0, queue unchanged. Then clr_err → READY, head_val=1.
- Empty queue, POP → err_code=10. Then clr_err and one PUSH → count 1.
- Full queue, GET_AND_PUSH with result=0xAA → count 15, tail entry=0xAA. Then run 20 alternating PUSH/POP commands across pointer wrap and check FIFO order.
- Any command with calc_err=1 → err_code=11, queue unchanged. Assert rst mid-ERROR → all reset values next cycle.
